rs_alu: RTL

- Reservation station for the integer ALU path.
- Sits between dispatch and the ALU execution unit, whose `issue_i` input it drives.
- Buffers up to ENTRY_NUM dispatched ALU ops and captures missing source operands from writeback broadcasts.
- Each cycle it selects one ready entry and issues it to the ALU unit, which accepts every cycle (single-cycle, no backpressure).

---
 rtl/rs_alu_pkg.sv | 35 +++
 rtl/rs_alu_select.sv | 52 +++++
 rtl/rs_alu.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rs_alu_pkg.sv
// rs_alu_pkg: shared constants and types for the ALU reservation station.
//   RRF_SEL, DATA_LEN, ADDR_LEN     : rename-register tag, data and address widths
//   ALU_OP_WIDTH, SRC_*_SEL_WIDTH   : ALU operation and operand mux select widths
//   RS_ALU_ENTRY_NUM/ENTRY_SEL      : default station depth and its log2
//   rs_alu_fields_t                 : per-entry payload carried unchanged to the ALU
// Optional feature macro used by the importing files: RS_ALU_AGE_SELECT_EN.
package rs_alu_pkg;

  localparam int RRF_SEL          = 6;
  localparam int DATA_LEN         = 32;
  localparam int ADDR_LEN         = 32;
  localparam int ALU_OP_WIDTH     = 4;
  localparam int SRC_A_SEL_WIDTH  = 2;
  localparam int SRC_B_SEL_WIDTH  = 2;
  localparam int RS_ALU_ENTRY_NUM = 8;
  localparam int RS_ALU_ENTRY_SEL = 3;

  typedef struct packed {
    logic [ADDR_LEN-1:0]        pc;
    logic [DATA_LEN-1:0]        imm;
    logic [ALU_OP_WIDTH-1:0]    alu_op;
    logic [SRC_A_SEL_WIDTH-1:0] src_a_select;
    logic [SRC_B_SEL_WIDTH-1:0] src_b_select;
    logic [RRF_SEL-1:0]         rrftag;
    logic                       if_write_rrf;
  } rs_alu_fields_t;

  // A waiting operand keeps its tag in the low RRF_SEL bits of its data slot.
  function automatic logic tag_hit(input logic               bc_valid,
                                   input logic [RRF_SEL-1:0] bc_tag,
                                   input logic [DATA_LEN-1:0] slot);
    return bc_valid && (slot[RRF_SEL-1:0] == bc_tag);
  endfunction

endpackage

// File: rtl/rs_alu_select.sv
// rs_alu_select: picks one entry out of a ready vector.
//   ready_i       : per-entry eligibility
//   age_i         : per-entry age (only when RS_ALU_AGE_SELECT_EN is defined)
//   grant_idx_o   : chosen entry index (0 when nothing is ready)
//   grant_valid_o : at least one entry is ready
// Without RS_ALU_AGE_SELECT_EN this is a lowest-index priority encoder; with it,
// the largest age wins and ties fall to the lowest index.
module rs_alu_select
  import rs_alu_pkg::*;
#(
  parameter int ENTRY_NUM = RS_ALU_ENTRY_NUM,
  parameter int ENTRY_SEL = RS_ALU_ENTRY_SEL
) (
  input  logic [ENTRY_NUM-1:0]                ready_i,
`ifdef RS_ALU_AGE_SELECT_EN
  input  logic [ENTRY_NUM-1:0][ENTRY_SEL-1:0] age_i,
`endif
  output logic [ENTRY_SEL-1:0]                grant_idx_o,
  output logic                                grant_valid_o
);

`ifdef RS_ALU_AGE_SELECT_EN
  logic [ENTRY_SEL-1:0] best_age;

  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    best_age      = '0;
    // Strictly-greater compare while scanning upward keeps ties on the lowest index.
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (ready_i[i] && (!grant_valid_o || (age_i[i] > best_age))) begin
        grant_idx_o   = ENTRY_SEL'(i);
        grant_valid_o = 1'b1;
        best_age      = age_i[i];
      end
    end
  end
`else
  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    // Scan downward so the last hit written is the lowest index.
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        grant_idx_o   = ENTRY_SEL'(i);
        grant_valid_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rs_alu.sv
// rs_alu: reservation station in front of the single-cycle integer ALU.
//   clk_i, reset_i (sync, active high), kill_i (flush all entries)
//   dispatch_*  : one op per cycle in, dispatch_ready_o while not full
//   wb_*        : two writeback broadcast ports used to wake waiting operands
//   issue_o + issued fields : at most one ready op per cycle to the ALU
//   entry_count_o : number of occupied entries
// Optional feature: RS_ALU_AGE_SELECT_EN enables oldest-first select using a
// saturating per-entry age; the default build selects the lowest ready index.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int ENTRY_NUM = RS_ALU_ENTRY_NUM,
  parameter int ENTRY_SEL = RS_ALU_ENTRY_SEL
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       kill_i,
  input  logic                       dispatch_valid_i,
  output logic                       dispatch_ready_o,
  input  logic [ADDR_LEN-1:0]        pc_i,
  input  logic [DATA_LEN-1:0]        imm_i,
  input  logic [ALU_OP_WIDTH-1:0]    alu_op_i,
  input  logic [SRC_A_SEL_WIDTH-1:0] src_a_select_i,
  input  logic [SRC_B_SEL_WIDTH-1:0] src_b_select_i,
  input  logic [DATA_LEN-1:0]        src1_i,
  input  logic [DATA_LEN-1:0]        src2_i,
  input  logic                       valid1_i,
  input  logic                       valid2_i,
  input  logic [RRF_SEL-1:0]         rrftag_i,
  input  logic                       if_write_rrf_i,
  input  logic [1:0]                 wb_valid_i,
  input  logic [RRF_SEL-1:0]         wb_tag0_i,
  input  logic [RRF_SEL-1:0]         wb_tag1_i,
  input  logic [DATA_LEN-1:0]        wb_data0_i,
  input  logic [DATA_LEN-1:0]        wb_data1_i,
  output logic                       issue_o,
  output logic [ADDR_LEN-1:0]        pc_o,
  output logic [DATA_LEN-1:0]        imm_o,
  output logic [ALU_OP_WIDTH-1:0]    alu_op_o,
  output logic [SRC_A_SEL_WIDTH-1:0] src_a_select_o,
  output logic [SRC_B_SEL_WIDTH-1:0] src_b_select_o,
  output logic [DATA_LEN-1:0]        src1_o,
  output logic [DATA_LEN-1:0]        src2_o,
  output logic [RRF_SEL-1:0]         rrftag_o,
  output logic                       if_write_rrf_o,
  output logic [ENTRY_SEL:0]         entry_count_o
);

  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic [ENTRY_NUM-1:0] rdy1_q, rdy1_d;
  logic [ENTRY_NUM-1:0] rdy2_q, rdy2_d;
  logic [DATA_LEN-1:0]  op1_q [ENTRY_NUM];
  logic [DATA_LEN-1:0]  op1_d [ENTRY_NUM];
  logic [DATA_LEN-1:0]  op2_q [ENTRY_NUM];
  logic [DATA_LEN-1:0]  op2_d [ENTRY_NUM];
  rs_alu_fields_t       fields_q [ENTRY_NUM];
  rs_alu_fields_t       fields_d [ENTRY_NUM];
  logic [ENTRY_SEL:0]   count_q, count_d;
`ifdef RS_ALU_AGE_SELECT_EN
  logic [ENTRY_NUM-1:0][ENTRY_SEL-1:0] age_q, age_d;
`endif

  logic [ENTRY_NUM-1:0] eligible;
  logic [ENTRY_SEL-1:0] grant_idx;
  logic                 grant_valid;
  logic [ENTRY_SEL-1:0] free_idx;
  logic                 accept;
  logic                 disp_rdy1, disp_rdy2;
  logic [DATA_LEN-1:0]  disp_op1, disp_op2;
  rs_alu_fields_t       disp_fields;
  rs_alu_fields_t       sel_fields;

  // Eligibility looks only at registered state, so a dispatch or wakeup in
  // cycle n cannot issue before n+1.
  for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_elig
    assign eligible[gi] = valid_q[gi] & rdy1_q[gi] & rdy2_q[gi];
  end

  rs_alu_select #(
    .ENTRY_NUM (ENTRY_NUM),
    .ENTRY_SEL (ENTRY_SEL)
  ) u_select (
    .ready_i       (eligible),
`ifdef RS_ALU_AGE_SELECT_EN
    .age_i         (age_q),
`endif
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign dispatch_ready_o = (count_q != (ENTRY_SEL + 1)'(ENTRY_NUM));
  assign accept           = dispatch_valid_i & dispatch_ready_o & ~kill_i & ~reset_i;
  assign issue_o          = grant_valid & ~kill_i & ~reset_i;
  assign entry_count_o    = count_q;

  // Lowest free slot from the pre-issue valid vector: a slot freed by this
  // cycle's issue is not reused until the next cycle.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = ENTRY_SEL'(i);
    end
  end

  // Incoming operands, including a wakeup by a broadcast in the dispatch cycle.
  always_comb begin
    disp_op1  = src1_i;
    disp_rdy1 = valid1_i;
    if (!valid1_i) begin
      if (tag_hit(wb_valid_i[0], wb_tag0_i, src1_i)) begin
        disp_op1  = wb_data0_i;
        disp_rdy1 = 1'b1;
      end else if (tag_hit(wb_valid_i[1], wb_tag1_i, src1_i)) begin
        disp_op1  = wb_data1_i;
        disp_rdy1 = 1'b1;
      end
    end
    disp_op2  = src2_i;
    disp_rdy2 = valid2_i;
    if (!valid2_i) begin
      if (tag_hit(wb_valid_i[0], wb_tag0_i, src2_i)) begin
        disp_op2  = wb_data0_i;
        disp_rdy2 = 1'b1;
      end else if (tag_hit(wb_valid_i[1], wb_tag1_i, src2_i)) begin
        disp_op2  = wb_data1_i;
        disp_rdy2 = 1'b1;
      end
    end
    disp_fields = '{pc: pc_i, imm: imm_i, alu_op: alu_op_i,
                    src_a_select: src_a_select_i, src_b_select: src_b_select_i,
                    rrftag: rrftag_i, if_write_rrf: if_write_rrf_i};
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
`ifdef RS_ALU_AGE_SELECT_EN
    age_d   = age_q;
`endif
    for (int i = 0; i < ENTRY_NUM; i++) begin
      op1_d[i]    = op1_q[i];
      op2_d[i]    = op2_q[i];
      fields_d[i] = fields_q[i];

      // Wakeup: port 0 wins if both ports carry the operand's tag.
      if (valid_q[i] && !rdy1_q[i]) begin
        if (tag_hit(wb_valid_i[0], wb_tag0_i, op1_q[i])) begin
          op1_d[i]  = wb_data0_i;
          rdy1_d[i] = 1'b1;
        end else if (tag_hit(wb_valid_i[1], wb_tag1_i, op1_q[i])) begin
          op1_d[i]  = wb_data1_i;
          rdy1_d[i] = 1'b1;
        end
      end
      if (valid_q[i] && !rdy2_q[i]) begin
        if (tag_hit(wb_valid_i[0], wb_tag0_i, op2_q[i])) begin
          op2_d[i]  = wb_data0_i;
          rdy2_d[i] = 1'b1;
        end else if (tag_hit(wb_valid_i[1], wb_tag1_i, op2_q[i])) begin
          op2_d[i]  = wb_data1_i;
          rdy2_d[i] = 1'b1;
        end
      end

`ifdef RS_ALU_AGE_SELECT_EN
      if (valid_q[i] && (age_q[i] != {ENTRY_SEL{1'b1}})) begin
        age_d[i] = age_q[i] + 1'b1;
      end
`endif

      if (issue_o && (grant_idx == ENTRY_SEL'(i))) begin
        valid_d[i] = 1'b0;
      end

      // The free slot is never the issued slot, so this cannot collide.
      if (accept && (free_idx == ENTRY_SEL'(i))) begin
        valid_d[i]  = 1'b1;
        fields_d[i] = disp_fields;
        op1_d[i]    = disp_op1;
        rdy1_d[i]   = disp_rdy1;
        op2_d[i]    = disp_op2;
        rdy2_d[i]   = disp_rdy2;
`ifdef RS_ALU_AGE_SELECT_EN
        age_d[i]    = '0;
`endif
      end
    end
    count_d = count_q + (ENTRY_SEL + 1)'(accept) - (ENTRY_SEL + 1)'(issue_o);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || kill_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
    // Payload needs no reset: it is only observed through a valid entry.
    rdy1_q <= rdy1_d;
    rdy2_q <= rdy2_d;
`ifdef RS_ALU_AGE_SELECT_EN
    age_q  <= age_d;
`endif
    for (int i = 0; i < ENTRY_NUM; i++) begin
      op1_q[i]    <= op1_d[i];
      op2_q[i]    <= op2_d[i];
      fields_q[i] <= fields_d[i];
    end
  end

  // Issued fields are zeroed whenever nothing issues.
  always_comb begin
    sel_fields     = fields_q[grant_idx];
    pc_o           = '0;
    imm_o          = '0;
    alu_op_o       = '0;
    src_a_select_o = '0;
    src_b_select_o = '0;
    src1_o         = '0;
    src2_o         = '0;
    rrftag_o       = '0;
    if_write_rrf_o = 1'b0;
    if (issue_o) begin
      pc_o           = sel_fields.pc;
      imm_o          = sel_fields.imm;
      alu_op_o       = sel_fields.alu_op;
      src_a_select_o = sel_fields.src_a_select;
      src_b_select_o = sel_fields.src_b_select;
      src1_o         = op1_q[grant_idx];
      src2_o         = op2_q[grant_idx];
      rrftag_o       = sel_fields.rrftag;
      if_write_rrf_o = sel_fields.if_write_rrf;
    end
  end

endmodule
